// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter: state encodings
// and the pattern-length normalisation helper.
package seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_SEND = ST_SEND,
    S_GAP  = ST_GAP,
    S_DONE = ST_DONE
  } state_e;

  // A length of 0, or one longer than the register, means "use the whole register".
  function automatic int unsigned norm_len(input int unsigned len, input int unsigned width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/seq_gen_if.sv
// Handshake and serial-output bundle between a pattern source and seq_gen.
interface seq_gen_if #(
  parameter int WIDTH = 8,
  parameter int LW    = 4,
  parameter int RW    = 4
);

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LW-1:0]    len;
  logic [RW-1:0]    rpt;
  logic             stop;
  logic             x_out;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, rpt, stop,
    input  x_out, x_valid, busy, done
  );

  modport slave (
    input  start, pattern, len, rpt, stop,
    output x_out, x_valid, busy, done
  );

endinterface

// File: rtl/seq_shreg.sv
// Loadable left-shift register; the serial bit is taken from a selectable
// position so that short patterns leave the top of the register unused.
module seq_shreg #(
  parameter int WIDTH = 8,
  parameter int IW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_val,
  input  logic [IW-1:0]    first_idx,
  output logic             bit_out
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_val;
    end else if (shift) begin
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign bit_out = sr_q[first_idx];

endmodule

// File: rtl/seq_gen.sv
// Serial bit-pattern transmitter: loads a pattern on start, shifts it out MSB
// of the used field first, optionally repeating with an idle gap in between.
module seq_gen
  import seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LW    = 4,
  parameter int RW    = 4,
  parameter int GAP   = 2
) (
  input  logic       clk,
  input  logic       reset,
  seq_gen_if.slave   bus
);

  localparam int IW     = $clog2(WIDTH);
  localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    bcnt_q, bcnt_d;
  logic [RW-1:0]    rpt_q, rpt_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             stop_seen_q, stop_seen_d;
  logic             x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sr_load;
  logic             sr_shift;
  logic [WIDTH-1:0] sr_val;
  logic             sr_bit;
  logic [LW-1:0]    len_in;
  logic [IW-1:0]    in_last;
  logic             stop_now;
  logic             last_rep;
  logic             reload;

  assign len_in  = bus.len;
  assign in_last = IW'(norm_len(32'(len_in), WIDTH) - 1);

  // The register is loaded already advanced by one: the first bit goes straight
  // to x_out on the loading edge, so the register only has to supply the rest.
  seq_shreg #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .load      (sr_load),
    .shift     (sr_shift),
    .load_val  (sr_val),
    .first_idx (last_q),
    .bit_out   (sr_bit)
  );

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    last_d      = last_q;
    bcnt_d      = bcnt_q;
    rpt_d       = rpt_q;
    rcnt_d      = rcnt_q;
    gcnt_d      = gcnt_q;
    stop_seen_d = stop_seen_q;
    x_out_d     = 1'b0;
    x_valid_d   = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_val      = pat_q << 1;
    reload      = 1'b0;
    stop_now    = stop_seen_q | bus.stop;
    last_rep    = (rpt_q != '0) && (rcnt_q == RW'(1));

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_SEND;
          pat_d       = bus.pattern;
          last_d      = in_last;
          bcnt_d      = in_last;
          rpt_d       = bus.rpt;
          rcnt_d      = bus.rpt;
          stop_seen_d = bus.stop;
          sr_load     = 1'b1;
          sr_val      = bus.pattern << 1;
          x_out_d     = bus.pattern[in_last];
          x_valid_d   = 1'b1;
        end
      end

      S_SEND: begin
        stop_seen_d = stop_now;
        if (bcnt_q != '0) begin
          bcnt_d    = bcnt_q - IW'(1);
          sr_shift  = 1'b1;
          x_out_d   = sr_bit;
          x_valid_d = 1'b1;
        end else begin
          // Last bit of this repetition is on x_out now.
          if (rpt_q != '0) begin
            rcnt_d = rcnt_q - RW'(1);
          end
          if (stop_now || last_rep) begin
            state_d = S_DONE;
          end else if (GAP > 0) begin
            state_d = S_GAP;
            gcnt_d  = GW'(GAP_M1);
          end else begin
            reload = 1'b1;
          end
        end
      end

      S_GAP: begin
        stop_seen_d = stop_now;
        if (gcnt_q != '0) begin
          gcnt_d = gcnt_q - GW'(1);
        end else if (stop_now) begin
          state_d = S_DONE;
        end else begin
          reload = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Next repetition restarts from the latched copy, not from the live inputs.
    if (reload) begin
      state_d     = S_SEND;
      bcnt_d      = last_q;
      stop_seen_d = 1'b0;
      sr_load     = 1'b1;
      sr_val      = pat_q << 1;
      x_out_d     = pat_q[last_q];
      x_valid_d   = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      last_q      <= '0;
      bcnt_q      <= '0;
      rpt_q       <= '0;
      rcnt_q      <= '0;
      gcnt_q      <= '0;
      stop_seen_q <= 1'b0;
      x_out_q     <= 1'b0;
      x_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      last_q      <= last_d;
      bcnt_q      <= bcnt_d;
      rpt_q       <= rpt_d;
      rcnt_q      <= rcnt_d;
      gcnt_q      <= gcnt_d;
      stop_seen_q <= stop_seen_d;
      x_out_q     <= x_out_d;
      x_valid_q   <= x_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.x_out   = x_out_q;
  assign bus.x_valid = x_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: a GAP=2 and a GAP=0 instance, each compared every cycle
// against an expected-output stream built from the transmit rules.
module tb_seq_gen;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_gen_if #(.WIDTH(8), .LW(4), .RW(4)) if2 ();
  seq_gen_if #(.WIDTH(8), .LW(4), .RW(4)) if0 ();

  seq_gen #(.WIDTH(8), .LW(4), .RW(4), .GAP(2)) u_g2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  seq_gen #(.WIDTH(8), .LW(4), .RW(4), .GAP(0)) u_g0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Expected {x_out, x_valid, busy, done} per cycle; an empty queue means idle.
  logic [3:0]  exp_q2[$];
  logic [3:0]  exp_q0[$];
  logic [63:0] hist2 = '0;
  logic [63:0] hist0 = '0;
  int vcnt2 = 0, vcnt0 = 0, dcnt2 = 0, dcnt0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected stream: one idle cycle before the start edge takes effect, then
  // each repetition MSB-first, gap cycles between repetitions, one done cycle.
  function automatic void push_model(input bit to0, input logic [7:0] pat, input int len,
                                     input int rpt, input int gap, input int stop_rep);
    int l;
    int reps;
    logic [3:0] s[$];
    l = (len == 0 || len > 8) ? 8 : len;
    if (rpt == 0) reps = stop_rep;
    else if (stop_rep > 0 && stop_rep < rpt) reps = stop_rep;
    else reps = rpt;
    s.push_back(4'b0000);
    for (int r = 1; r <= reps; r++) begin
      for (int i = l - 1; i >= 0; i--) s.push_back({pat[i], 3'b110});
      if (r < reps) for (int g = 0; g < gap; g++) s.push_back(4'b0010);
    end
    s.push_back(4'b0011);
    foreach (s[k]) begin
      if (to0) exp_q0.push_back(s[k]);
      else exp_q2.push_back(s[k]);
    end
  endfunction

  task automatic drive(input bit to0, input logic [7:0] pat, input logic [3:0] len,
                       input logic [3:0] rpt, input logic stp);
    if (to0) begin
      if0.pattern = pat; if0.len = len; if0.rpt = rpt; if0.stop = stp; if0.start = 1'b1;
    end else begin
      if2.pattern = pat; if2.len = len; if2.rpt = rpt; if2.stop = stp; if2.start = 1'b1;
    end
  endtask

  task automatic release_start();
    @(posedge clk); #1;
    if0.start = 1'b0; if0.stop = 1'b0;
    if2.start = 1'b0; if2.stop = 1'b0;
  endtask

  task automatic drain(input bit to0);
    int c;
    int left;
    string nm;
    c = 0;
    left = to0 ? exp_q0.size() : exp_q2.size();
    while (c < 400 && left != 0) begin
      @(posedge clk);
      c++;
      left = to0 ? exp_q0.size() : exp_q2.size();
    end
    nm = to0 ? "drain_g0" : "drain_g2";
    check(nm, left, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int v0;
    int d0;
    int c;
    logic done_seen;

    if2.start = 1'b0; if2.stop = 1'b0; if2.pattern = '0; if2.len = '0; if2.rpt = '0;
    if0.start = 1'b0; if0.stop = 1'b0; if0.pattern = '0; if0.len = '0; if0.rpt = '0;

    fork
      forever begin : cmp
        logic [3:0] e2, e0;
        @(negedge clk);
        e2 = (exp_q2.size() != 0) ? exp_q2.pop_front() : 4'b0000;
        e0 = (exp_q0.size() != 0) ? exp_q0.pop_front() : 4'b0000;
        check("cycle_g2", {if2.x_out, if2.x_valid, if2.busy, if2.done}, e2);
        check("cycle_g0", {if0.x_out, if0.x_valid, if0.busy, if0.done}, e0);
        if (if2.x_valid) begin hist2 = {hist2[62:0], if2.x_out}; vcnt2++; end
        if (if0.x_valid) begin hist0 = {hist0[62:0], if0.x_out}; vcnt0++; end
        if (if2.done) dcnt2++;
        if (if0.done) dcnt0++;
      end
    join_none

    // Reset
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("reset_outs_g2", {if2.x_out, if2.x_valid, if2.busy, if2.done}, 4'b0000);
    check("reset_outs_g0", {if0.x_out, if0.x_valid, if0.busy, if0.done}, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;

    // Full 8-bit pattern, single repetition, done on cycle 9, idle on cycle 10
    v0 = vcnt2;
    push_model(1'b0, 8'b1011_0010, 0, 1, 2, 0);
    drive(1'b0, 8'b1011_0010, 4'd0, 4'd1, 1'b0);
    c = 0;
    done_seen = 1'b0;
    while (c < 40 && !done_seen) begin
      @(posedge clk); #1;
      c++;
      if (c == 1) begin
        check("t1_first_bit", {if2.x_out, if2.x_valid}, 2'b11);
        if2.start = 1'b0;
      end
      done_seen = if2.done;
    end
    check("t1_done_cycle", c, 9);
    @(posedge clk); #1;
    check("t1_busy_c10", if2.busy, 1'b0);
    @(posedge clk); #1;
    check("t1_nbits", vcnt2 - v0, 8);
    check("t1_bits", hist2[7:0], 8'b1011_0010);

    // stop alone in IDLE is ignored; then len=3, rpt=2 with a 2-cycle gap
    if2.stop = 1'b1;
    @(posedge clk); #1;
    if2.stop = 1'b0;
    v0 = vcnt2;
    push_model(1'b0, 8'b1111_1101, 3, 2, 2, 0);
    drive(1'b0, 8'b1111_1101, 4'd3, 4'd2, 1'b0);
    release_start();
    drain(1'b0);
    check("t2_nbits", vcnt2 - v0, 6);
    check("t2_bits", hist2[5:0], 6'b101_101);

    // Continuous mode, no gap, stop during third repetition
    v0 = vcnt0;
    d0 = dcnt0;
    push_model(1'b1, 8'h0F, 4, 0, 0, 3);
    drive(1'b1, 8'h0F, 4'd4, 4'd0, 1'b0);
    release_start();
    repeat (9) @(posedge clk);
    #1 if0.stop = 1'b1;
    @(posedge clk); #1;
    if0.stop = 1'b0;
    drain(1'b1);
    check("t3_nbits", vcnt0 - v0, 12);
    check("t3_bits", hist0[11:0], 12'hFFF);
    check("t3_done_pulses", dcnt0 - d0, 1);

    // Second start mid-transfer with a different pattern is ignored
    v0 = vcnt2;
    d0 = dcnt2;
    push_model(1'b0, 8'hC6, 8, 1, 2, 0);
    drive(1'b0, 8'hC6, 4'd8, 4'd1, 1'b0);
    release_start();
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 8'h3C, 4'd8, 4'd1, 1'b0);
    release_start();
    drain(1'b0);
    check("t4_nbits", vcnt2 - v0, 8);
    check("t4_bits", hist2[7:0], 8'hC6);
    check("t4_done_pulses", dcnt2 - d0, 1);

    // Asynchronous reset mid-SEND
    push_model(1'b0, 8'hF0, 8, 1, 2, 0);
    drive(1'b0, 8'hF0, 4'd8, 4'd1, 1'b0);
    release_start();
    repeat (3) @(posedge clk);
    #2;
    check("t5_pre_reset", {if2.x_out, if2.x_valid, if2.busy}, 3'b111);
    reset = 1'b0;
    exp_q2.delete();
    #1;
    check("t5_async_clear", {if2.x_out, if2.x_valid, if2.busy, if2.done}, 4'b0000);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    v0 = vcnt2;
    repeat (6) @(posedge clk);
    #1;
    check("t5_quiet_after", vcnt2 - v0, 0);

    // len beyond WIDTH uses the full register; also the restart after reset
    v0 = vcnt2;
    push_model(1'b0, 8'hA5, 9, 1, 2, 0);
    drive(1'b0, 8'hA5, 4'd9, 4'd1, 1'b0);
    release_start();
    drain(1'b0);
    check("t6_nbits", vcnt2 - v0, 8);
    check("t6_bits", hist2[7:0], 8'hA5);

    // start and stop together: exactly one repetition even with rpt=3
    v0 = vcnt2;
    push_model(1'b0, 8'h5A, 2, 3, 2, 1);
    drive(1'b0, 8'h5A, 4'd2, 4'd3, 1'b1);
    release_start();
    drain(1'b0);
    check("t7_nbits", vcnt2 - v0, 2);
    check("t7_bits", hist2[1:0], 2'b10);

    // Maximum repeat count, one bit per repetition
    v0 = vcnt2;
    push_model(1'b0, 8'h01, 1, 15, 2, 0);
    drive(1'b0, 8'h01, 4'd1, 4'd15, 1'b0);
    release_start();
    drain(1'b0);
    check("t8_nbits", vcnt2 - v0, 15);
    check("t8_bits", hist2[14:0], 15'h7FFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
